// File: rtl/seg_pkg.sv
// Shared segment patterns and digit codes for the seven-segment scan path.
// Patterns are active-low with bit 7 = decimal point and bits 6..0 = g..a.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg_decode.sv
// Maps a 4-bit digit code to a 7-bit active-low g..a pattern; purely combinational.
// Latency 0; no flow control (decimal point and blanking are applied by the parent).
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    logic [7:0] pat;

    always_comb begin
        pat = SEG_BLANK;
        case (code)
            4'd0:      pat = SEG_0;
            4'd1:      pat = SEG_1;
            4'd2:      pat = SEG_2;
            4'd3:      pat = SEG_3;
            4'd4:      pat = SEG_4;
            4'd5:      pat = SEG_5;
            4'd6:      pat = SEG_6;
            4'd7:      pat = SEG_7;
            4'd8:      pat = SEG_8;
            4'd9:      pat = SEG_9;
            CODE_DASH: pat = SEG_DASH;
            default:   pat = SEG_BLANK;
        endcase
        seg_n = pat[6:0];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode scanner with prescaler, double-buffered digits, blink and dp.
// Outputs registered, 1 clk after position/buffer state; no backpressure, uLoad always accepted.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uEn,
    input  logic                  uLoad,
    input  logic [4*DIGITS-1:0]   uData,
    input  logic [DIGITS-1:0]     uBlink,
    input  logic [DIGITS-1:0]     uDp,
    output logic [7:0]            ySEG_,
    output logic [DIGITS-1:0]     yAN_,
    output logic                  yFrame
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [AW-1:0] POS_MAX   = AW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   blink;
        logic [DIGITS-1:0]   dp;
    } buf_t;

    localparam buf_t BUF_RST = '{data: {DIGITS{CODE_BLANK}}, blink: '0, dp: '0};

    logic [PW-1:0]     presc_q, presc_d;
    logic [AW-1:0]     pos_q, pos_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              phase_q, phase_d;
    logic              pending_q, pending_d;
    buf_t              shadow_q, shadow_d;
    buf_t              active_q, active_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_pulse_q, frame_pulse_d;

    logic              tick;
    logic              wrap;
    logic [3:0]        cur_code;
    logic              cur_blink;
    logic              cur_dp;
    logic [6:0]        dec_seg;

    seg_decode u_dec (
        .code  (cur_code),
        .seg_n (dec_seg)
    );

    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        wrap      = tick && (pos_q == POS_MAX);

        presc_d   = tick ? '0 : presc_q + 1'b1;

        pos_d     = pos_q;
        if (tick) begin
            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
        end

        frame_d   = frame_q;
        phase_d   = phase_q;
        if (wrap) begin
            if (frame_q == FRAME_MAX) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end

        // Transfer takes the pre-edge shadow, so a load on the wrap cycle waits one more frame.
        active_d  = (wrap && pending_q) ? shadow_q : active_q;
        shadow_d  = uLoad ? '{data: uData, blink: uBlink, dp: uDp} : shadow_q;
        pending_d = uLoad ? 1'b1 : (wrap ? 1'b0 : pending_q);

        cur_code  = 4'(active_q.data >> {pos_q, 2'b00});
        cur_blink = active_q.blink[pos_q];
        cur_dp    = active_q.dp[pos_q];

        seg_d     = SEG_BLANK;
        an_d      = '1;
        if (uEn) begin
            an_d = ~(DIGITS'(1) << pos_q);
            if (!(phase_q && cur_blink)) begin
                seg_d = {~cur_dp, dec_seg};
            end
        end

        frame_pulse_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            pos_q         <= '0;
            frame_q       <= '0;
            phase_q       <= 1'b0;
            pending_q     <= 1'b0;
            shadow_q      <= BUF_RST;
            active_q      <= BUF_RST;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            frame_pulse_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            pos_q         <= pos_d;
            frame_q       <= frame_d;
            phase_q       <= phase_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    assign ySEG_  = seg_q;
    assign yAN_   = an_q;
    assign yFrame = frame_pulse_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: arithmetic reference model plus directed literal checks.
module tb_seg_scan_driver;

    localparam int D  = 4;
    localparam int CD = 2;
    localparam int BF = 2;
    localparam int P  = D * CD;
    localparam int D1 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        uEn = 1'b1;
    logic        uLoad = 1'b0;
    logic [15:0] uData = 16'h0;
    logic [3:0]  uBlink = 4'h0;
    logic [3:0]  uDp = 4'h0;
    logic [7:0]  ySEG_;
    logic [3:0]  yAN_;
    logic        yFrame;
    logic [7:0]  ySEG1;
    logic [2:0]  yAN1;
    logic        yFrame1;

    int errors = 0;
    int checks = 0;

    // Reference model state: n counts clock edges since reset release.
    int          n = 0;
    logic [15:0] sh_d = 16'hFFFF, ac_d = 16'hFFFF;
    logic [3:0]  sh_b = 4'h0, ac_b = 4'h0, sh_p = 4'h0, ac_p = 4'h0;
    logic [7:0]  tab [16];
    logic [3:0]  scan_exp [8];

    seg_scan_driver #(.DIGITS(D), .CLK_DIV(CD), .BLINK_FRAMES(BF)) dut (
        .clk    (clk),
        .rst    (rst),
        .uEn    (uEn),
        .uLoad  (uLoad),
        .uData  (uData),
        .uBlink (uBlink),
        .uDp    (uDp),
        .ySEG_  (ySEG_),
        .yAN_   (yAN_),
        .yFrame (yFrame)
    );

    seg_scan_driver #(.DIGITS(D1), .CLK_DIV(1), .BLINK_FRAMES(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .uEn    (uEn),
        .uLoad  (uLoad),
        .uData  (uData[11:0]),
        .uBlink (uBlink[2:0]),
        .uDp    (uDp[2:0]),
        .ySEG_  (ySEG1),
        .yAN_   (yAN1),
        .yFrame (yFrame1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model and per-cycle compare process.
    always @(posedge clk) begin
        logic [7:0] es;
        logic [3:0] ea;
        logic [2:0] ea1;
        logic       ef, ef1, en;
        logic [3:0] code;
        int         p, ph, p1;
        en = uEn;
        if (rst) begin
            n = 0;
            sh_d = 16'hFFFF; ac_d = 16'hFFFF;
            sh_b = 4'h0; ac_b = 4'h0; sh_p = 4'h0; ac_p = 4'h0;
            es = 8'hFF; ea = 4'hF; ef = 1'b0; ea1 = 3'h7; ef1 = 1'b0;
        end else begin
            p    = (n / CD) % D;
            ph   = ((n / P) / BF) % 2;
            code = 4'(ac_d >> (4 * p));
            if (!uEn || (ac_b[p] && ph == 1)) es = 8'hFF;
            else                              es = {~ac_p[p], tab[code][6:0]};
            ea   = uEn ? ~(4'b0001 << p) : 4'hF;
            p1   = n % D1;
            ea1  = uEn ? ~(3'b001 << p1) : 3'h7;
            n    = n + 1;
            ef   = (n % P == 0);
            ef1  = (n % D1 == 0);
            if (n % P == 0) begin
                ac_d = sh_d; ac_b = sh_b; ac_p = sh_p;
            end
            if (uLoad) begin
                sh_d = uData; sh_b = uBlink; sh_p = uDp;
            end
        end
        #1;
        chk("model_seg", ySEG_, es);
        chk("model_an", yAN_, ea);
        chk("model_frame", yFrame, ef);
        chk("model_an_div1", yAN1, ea1);
        chk("model_frame_div1", yFrame1, ef1);
        if (!en || rst) chk("model_seg_div1_off", ySEG1, 8'hFF);
    end

    task automatic wait_an(input logic [3:0] pat, input string name);
        int k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (yAN_ !== pat && k < 100);
        chk(name, yAN_, pat);
    endtask

    task automatic wait_frame(input string name);
        int k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (yFrame !== 1'b1 && k < 100);
        chk(name, yFrame, 1'b1);
    endtask

    // Called at a negedge; returns at the following negedge with uLoad low.
    task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] dp);
        uData = d; uBlink = b; uDp = dp; uLoad = 1'b1;
        @(negedge clk);
        uLoad = 1'b0;
    endtask

    initial begin
        int ffcnt;
        tab[0] = 8'hC0; tab[1] = 8'hF9; tab[2] = 8'hA4; tab[3] = 8'hB0;
        tab[4] = 8'h99; tab[5] = 8'h92; tab[6] = 8'h82; tab[7] = 8'hF8;
        tab[8] = 8'h80; tab[9] = 8'h90; tab[10] = 8'hBF;
        for (int i = 11; i < 16; i++) tab[i] = 8'hFF;
        scan_exp[0] = 4'b1110; scan_exp[1] = 4'b1110; scan_exp[2] = 4'b1101; scan_exp[3] = 4'b1101;
        scan_exp[4] = 4'b1011; scan_exp[5] = 4'b1011; scan_exp[6] = 4'b0111; scan_exp[7] = 4'b0111;

        // Reset and blank scan
        rst = 1'b1;
        #3;
        chk("reset_seg", ySEG_, 8'hFF);
        chk("reset_an", yAN_, 4'hF);
        chk("reset_frame", yFrame, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            chk("scan_an", yAN_, scan_exp[i]);
            chk("scan_seg_blank", ySEG_, 8'hFF);
        end

        // Tear-free load mid-frame
        @(negedge clk);
        while (n % P != 3) @(negedge clk);
        do_load(16'h3210, 4'h0, 4'h0);
        wait_frame("tear_frame");
        wait_an(4'b1110, "tear_an0"); chk("tear_pos0", ySEG_, 8'hC0);
        wait_an(4'b1101, "tear_an1"); chk("tear_pos1", ySEG_, 8'hF9);
        wait_an(4'b1011, "tear_an2"); chk("tear_pos2", ySEG_, 8'hA4);
        wait_an(4'b0111, "tear_an3"); chk("tear_pos3", ySEG_, 8'hB0);

        // Load coincident with wrap while a first load is pending
        @(negedge clk);
        while (n % P != 2) @(negedge clk);
        do_load(16'h1111, 4'h0, 4'h0);
        while ((n + 1) % P != 0) @(negedge clk);
        do_load(16'h2222, 4'h0, 4'h0);
        wait_an(4'b1110, "coin_an_a"); chk("coin_first", ySEG_, 8'hF9);
        wait_an(4'b1101, "coin_an_b");
        wait_an(4'b1110, "coin_an_c"); chk("coin_second", ySEG_, 8'hA4);

        // Blink and decimal point
        @(negedge clk);
        do_load(16'h4321, 4'b0010, 4'b0100);
        wait_frame("blink_f0");
        wait_frame("blink_f1");
        ffcnt = 0;
        for (int f = 0; f < 8; f++) begin
            wait_an(4'b1101, "blink_an1");
            if (ySEG_ == 8'hFF) ffcnt++;
            else chk("blink_pos1", ySEG_, 8'hA4);
            wait_an(4'b1011, "dp_an2");
            chk("dp_pos2", ySEG_, 8'h30);
        end
        chk("blink_ff_count", ffcnt, 4);

        // Codes and enable
        @(negedge clk);
        do_load(16'hFBA9, 4'h0, 4'h0);
        wait_frame("codes_f0");
        wait_frame("codes_f1");
        wait_an(4'b1110, "codes_an0"); chk("codes_pos0", ySEG_, 8'h90);
        wait_an(4'b1101, "codes_an1"); chk("codes_pos1", ySEG_, 8'hBF);
        wait_an(4'b1011, "codes_an2"); chk("codes_pos2", ySEG_, 8'hFF);
        wait_an(4'b0111, "codes_an3"); chk("codes_pos3", ySEG_, 8'hFF);
        @(negedge clk);
        uEn = 1'b0;
        @(posedge clk); #2;
        chk("en_off_an", yAN_, 4'hF);
        chk("en_off_seg", ySEG_, 8'hFF);
        @(negedge clk);
        do_load(16'h5678, 4'h0, 4'hF);
        wait_frame("en_off_frame");
        @(negedge clk);
        uEn = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            uLoad = ($urandom_range(0, 7) == 0);
            if (uLoad) begin
                uData  = 16'($urandom);
                uBlink = 4'($urandom);
                uDp    = 4'($urandom);
            end
            if ($urandom_range(0, 49) == 0) uEn = ~uEn;
        end
        @(negedge clk);
        uLoad = 1'b0;
        uEn = 1'b1;

        // Asynchronous reset mid-scan
        wait_an(4'b1011, "arst_pos2");
        #1 rst = 1'b1;
        #1;
        chk("arst_seg", ySEG_, 8'hFF);
        chk("arst_an", yAN_, 4'hF);
        chk("arst_frame", yFrame, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("arst_restart0", yAN_, 4'b1110);
        chk("arst_restart_seg", ySEG_, 8'hFF);
        @(posedge clk); #2;
        chk("arst_restart1", yAN_, 4'b1110);
        @(posedge clk); #2;
        chk("arst_restart2", yAN_, 4'b1101);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
